// File: rtl/x7seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment display driver.
package x7seg_pkg;

  localparam int DP_BIT = 7;

  // Active-high g..a patterns for hex digits 0-F.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h27,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h58, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic {S_BLANK, S_ON} state_e;

  // Ceiling log2, never below 1 so a single-digit build still gets a 1-bit index.
  function automatic int clog2(input int n);
    int w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/x7seg_scan_mux_if.sv
// Bundle of the display driver's datapath inputs and board-pin outputs.
interface x7seg_scan_mux_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] data;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    load;
  logic [7:0]              a_to_g;
  logic [NUM_DIGITS-1:0]   an;
  logic                    scan_tick;

  modport master (
    output data, dp_in, digit_en, load,
    input  a_to_g, an, scan_tick
  );

  modport slave (
    input  data, dp_in, digit_en, load,
    output a_to_g, an, scan_tick
  );
endinterface

// File: rtl/x7seg_hex_decode.sv
// Combinational nibble + decimal point to active-high 8-bit segment pattern.
module x7seg_hex_decode
  import x7seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg
);

  always_comb begin
    seg         = {1'b0, SEG_LUT[nibble]};
    seg[DP_BIT] = dp;
  end

endmodule

// File: rtl/x7seg_scan_mux.sv
// Time-multiplexed 7-segment scanner with per-slot blanking and registered pin outputs.
// Optional leading-zero suppression is built when X7SEG_ZERO_BLANK_EN is defined.
module x7seg_scan_mux
  import x7seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 100000,
  parameter int BLANK_CYCLES   = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  x7seg_scan_mux_if.slave  bus
);

  localparam int CNT_W = clog2(SCAN_DIV);
  localparam int IDX_W = clog2(NUM_DIGITS);
  localparam logic [7:0]            SEG_OFF = {8{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_ACTIVE_LOW}};

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  state_e                  state_q, state_d;
  logic                    wrap;
  logic [4*NUM_DIGITS-1:0] shadow_data_q;
  logic [NUM_DIGITS-1:0]   shadow_dp_q;
  logic [NUM_DIGITS-1:0]   dark;
  logic [3:0]              cur_nibble;
  logic                    cur_dp;
  logic [7:0]              cur_seg;
  logic                    lit;
  logic [NUM_DIGITS-1:0]   an_hot, an_d, an_q;
  logic [7:0]              seg_d, a_to_g_q;
  logic                    scan_tick_q;

`ifdef X7SEG_ZERO_BLANK_EN
  logic all_zero;

  // Walk from the most significant digit down; digit 0 always stays visible.
  always_comb begin
    all_zero = 1'b1;
    dark     = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero & (shadow_data_q[4*i +: 4] == 4'h0);
      if (i > 0) dark[i] = all_zero;
    end
  end
`else
  assign dark = '0;
`endif

  // NOTE: every signal written in a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    wrap    = (cnt_q == CNT_W'(SCAN_DIV - 1));
    cnt_d   = wrap ? '0 : cnt_q + 1'b1;
    idx_d   = idx_q;
    if (wrap) idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    state_d = (int'(cnt_d) < BLANK_CYCLES) ? S_BLANK : S_ON;
  end

  assign cur_nibble = shadow_data_q[4*idx_q +: 4];
  assign cur_dp     = shadow_dp_q[idx_q] & ~dark[idx_q];

  x7seg_hex_decode u_decode (
    .nibble (cur_nibble),
    .dp     (cur_dp),
    .seg    (cur_seg)
  );

  // Segments are forced off together with the anode so a dark slot drives nothing.
  always_comb begin
    lit            = (state_q == S_ON) && bus.digit_en[idx_q] && !dark[idx_q];
    an_hot         = '0;
    an_hot[idx_q]  = 1'b1;
    an_d           = lit ? (an_hot ^ AN_OFF) : AN_OFF;
    seg_d          = lit ? (cur_seg ^ SEG_OFF) : SEG_OFF;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      state_q       <= S_BLANK;
      // NOTE: the shadow registers are reset too, so a display that is never loaded shows zeros rather than X.
      shadow_data_q <= '0;
      shadow_dp_q   <= '0;
      a_to_g_q      <= SEG_OFF;
      an_q          <= AN_OFF;
      scan_tick_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      state_q     <= state_d;
      a_to_g_q    <= seg_d;
      an_q        <= an_d;
      scan_tick_q <= wrap;
      if (bus.load) begin
        shadow_data_q <= bus.data;
        shadow_dp_q   <= bus.dp_in;
      end
    end
  end

  assign bus.a_to_g    = a_to_g_q;
  assign bus.an        = an_q;
  assign bus.scan_tick = scan_tick_q;

endmodule

// File: tb/tb_x7seg_scan_mux.sv
// Directed bench for x7seg_scan_mux with SCAN_DIV=8, BLANK_CYCLES=2, four active-low digits.
// Expectations follow X7SEG_ZERO_BLANK_EN when the bench is built with it.
module tb_x7seg_scan_mux;

  localparam int ND = 4;
  localparam int SD = 8;
  localparam int BC = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  x7seg_scan_mux_if #(.NUM_DIGITS(ND)) bus ();

  x7seg_scan_mux #(
    .NUM_DIGITS     (ND),
    .SCAN_DIV       (SD),
    .BLANK_CYCLES   (BC),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit after a posedge with reset just released;
  // after edge k the outputs reflect slot position k-1.
  task automatic do_reset();
    rst_n    = 1'b0;
    bus.load = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    bus.digit_en = 4'hF;
    bus.data     = 16'h12AF;
    bus.dp_in    = 4'b0100;
    bus.load     = 1'b1;
    step();
    bus.load = 1'b0;
    repeat (11) step();
    checks++;
    if (bus.an !== 4'hD || bus.a_to_g !== 8'h88) begin
      errors++;
      $display("FAIL pre_reset_digit1: an=%h seg=%h expected an=d seg=88", bus.an, bus.a_to_g);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.a_to_g !== 8'hFF || bus.an !== 4'hF || bus.scan_tick !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: seg=%h an=%h tick=%b expected seg=ff an=f tick=0",
               bus.a_to_g, bus.an, bus.scan_tick);
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    checks++;
    if (bus.an !== 4'hF) begin
      errors++;
      $display("FAIL release_an: an=%h expected f", bus.an);
    end
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++;
      if (bus.scan_tick !== (k == 8)) begin
        errors++;
        $display("FAIL first_tick k=%0d: tick=%b expected %b", k, bus.scan_tick, (k == 8));
      end
      if (k == 3) begin
        checks++;
        if (bus.an !== 4'hE || bus.a_to_g !== 8'hC0) begin
          errors++;
          $display("FAIL cleared_shadow: an=%h seg=%h expected an=e seg=c0", bus.an, bus.a_to_g);
        end
      end
    end
  endtask

  task automatic test_scan();
    logic [7:0] tbl [4] = '{8'h8E, 8'h88, 8'h24, 8'hF9};
    logic [3:0] exp_an;
    logic [7:0] exp_seg;
    int m, d;
    do_reset();
    bus.digit_en = 4'hF;
    bus.data     = 16'h12AF;
    bus.dp_in    = 4'b0100;
    bus.load     = 1'b1;
    for (int k = 1; k <= 36; k++) begin
      step();
      bus.load = 1'b0;
      m = k - 1;
      d = (m / SD) % ND;
      exp_an  = 4'hF;
      exp_seg = 8'hFF;
      if ((m % SD) >= BC) begin
        exp_an[d] = 1'b0;
        exp_seg   = tbl[d];
      end
      checks++;
      if (bus.an !== exp_an || bus.a_to_g !== exp_seg || bus.scan_tick !== (k % SD == 0)) begin
        errors++;
        $display("FAIL scan k=%0d: an=%h seg=%h tick=%b expected an=%h seg=%h tick=%b",
                 k, bus.an, bus.a_to_g, bus.scan_tick, exp_an, exp_seg, (k % SD == 0));
      end
    end
  endtask

  task automatic test_enable();
    logic [7:0] tbl [4] = '{8'h8E, 8'h88, 8'h24, 8'hF9};
    logic [3:0] exp_an;
    logic [7:0] exp_seg;
    logic [3:0] en_pat [2] = '{4'b0101, 4'b0000};
    int m, d;
    for (int p = 0; p < 2; p++) begin
      do_reset();
      bus.digit_en = en_pat[p];
      bus.data     = 16'h12AF;
      bus.dp_in    = 4'b0100;
      bus.load     = 1'b1;
      for (int k = 1; k <= 33; k++) begin
        step();
        bus.load = 1'b0;
        m = k - 1;
        d = (m / SD) % ND;
        exp_an  = 4'hF;
        exp_seg = 8'hFF;
        if ((m % SD) >= BC && en_pat[p][d]) begin
          exp_an[d] = 1'b0;
          exp_seg   = tbl[d];
        end
        checks++;
        if (bus.an !== exp_an || bus.a_to_g !== exp_seg || bus.scan_tick !== (k % SD == 0)) begin
          errors++;
          $display("FAIL enable en=%b k=%0d: an=%h seg=%h tick=%b expected an=%h seg=%h tick=%b",
                   en_pat[p], k, bus.an, bus.a_to_g, bus.scan_tick, exp_an, exp_seg, (k % SD == 0));
        end
      end
    end
  endtask

  task automatic test_mid_load();
    do_reset();
    bus.digit_en = 4'hF;
    bus.data     = 16'h12AF;
    bus.dp_in    = 4'b0000;
    bus.load     = 1'b1;
    step();
    bus.load = 1'b0;
    repeat (3) step();
    checks++;
    if (bus.an !== 4'hE || bus.a_to_g !== 8'h8E) begin
      errors++;
      $display("FAIL mid_load_before: an=%h seg=%h expected an=e seg=8e", bus.an, bus.a_to_g);
    end
    bus.data = 16'h0009;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    checks++;
    if (bus.an !== 4'hE || bus.a_to_g !== 8'h8E) begin
      errors++;
      $display("FAIL mid_load_edge: an=%h seg=%h expected an=e seg=8e", bus.an, bus.a_to_g);
    end
    step();
    checks++;
    if (bus.an !== 4'hE || bus.a_to_g !== 8'h90) begin
      errors++;
      $display("FAIL mid_load_after: an=%h seg=%h expected an=e seg=90", bus.an, bus.a_to_g);
    end
  endtask

  task automatic test_zero_blank();
`ifdef X7SEG_ZERO_BLANK_EN
    logic [3:0] dk = 4'b1100;
`else
    logic [3:0] dk = 4'b0000;
`endif
    logic [7:0] tbl [4] = '{8'hC0, 8'hD8, 8'hC0, 8'hC0};
    logic [3:0] exp_an;
    logic [7:0] exp_seg;
    int m, d;
    do_reset();
    bus.digit_en = 4'hF;
    bus.data     = 16'h0070;
    bus.dp_in    = 4'b0000;
    bus.load     = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      step();
      bus.load = 1'b0;
      m = k - 1;
      d = (m / SD) % ND;
      exp_an  = 4'hF;
      exp_seg = 8'hFF;
      if ((m % SD) >= BC && !dk[d]) begin
        exp_an[d] = 1'b0;
        exp_seg   = tbl[d];
      end
      checks++;
      if (bus.an !== exp_an || bus.a_to_g !== exp_seg) begin
        errors++;
        $display("FAIL zero_blank k=%0d: an=%h seg=%h expected an=%h seg=%h",
                 k, bus.an, bus.a_to_g, exp_an, exp_seg);
      end
    end
  endtask

  initial begin
    bus.data     = '0;
    bus.dp_in    = '0;
    bus.digit_en = '0;
    bus.load     = 1'b0;
    test_reset();
    test_scan();
    test_enable();
    test_mid_load();
    test_zero_blank();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete within 100000 time units");
    $fatal(1, "timeout");
  end

endmodule
